gpu_dc_rect_fill: RTL and testbench

GPU_DC_RECT_FILL -- requirements
Module: gpu_dc_rect_fill

---
 rtl/gpu_dc_rect_fill.sv | 106 ++++++++++
 tb/tb_gpu_dc_rect_fill.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gpu_dc_rect_fill.sv
// Rectangle fill engine: streams one RGB444 pixel per handshake in raster order,
// clipped to the H_RES x V_RES framebuffer.
module gpu_dc_rect_fill #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [9:0]  width,
  input  logic [9:0]  height,
  input  logic [11:0] color,
  output logic        busy,
  output logic        done,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [18:0] px_addr,
  output logic [11:0] px_data
);

  localparam logic [10:0] H_MAX  = 11'(H_RES);
  localparam logic [10:0] V_MAX  = 11'(V_RES);
  localparam logic [18:0] H_STEP = 19'(H_RES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [10:0] x, y, x_start, x_end, y_end;
  logic [18:0] row_base;
  logic [11:0] color_r;

  logic [10:0] x_sum, y_sum, x_end_calc, y_end_calc;
  logic        degenerate, handshake, last_x, last_y;

  // 11-bit sums cannot overflow for 10-bit operands
  always_comb begin
    x_sum      = {1'b0, x0} + {1'b0, width};
    y_sum      = {1'b0, y0} + {1'b0, height};
    x_end_calc = (x_sum > H_MAX) ? H_MAX : x_sum;
    y_end_calc = (y_sum > V_MAX) ? V_MAX : y_sum;
    degenerate = (width == '0) || (height == '0) ||
                 ({1'b0, x0} >= H_MAX) || ({1'b0, y0} >= V_MAX);
  end

  assign handshake = (state == RUN) && px_ready;
  assign last_x    = (x == x_end - 11'd1);
  assign last_y    = (y == y_end - 11'd1);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = degenerate ? DONE : RUN;
      RUN:     if (handshake && last_x && last_y) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The multiply happens only at command latch; the address path is add-only
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      x        <= '0;
      y        <= '0;
      x_start  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      row_base <= '0;
      color_r  <= '0;
    end else if (state == IDLE && start) begin
      x        <= {1'b0, x0};
      y        <= {1'b0, y0};
      x_start  <= {1'b0, x0};
      x_end    <= x_end_calc;
      y_end    <= y_end_calc;
      row_base <= 19'(y0) * H_STEP;
      color_r  <= color;
    end else if (handshake) begin
      if (last_x) begin
        x        <= x_start;
        y        <= y + 11'd1;
        row_base <= row_base + H_STEP;
      end else begin
        x <= x + 11'd1;
      end
    end
  end

  assign busy     = (state == RUN);
  assign px_valid = (state == RUN);
  assign done     = (state == DONE);
  assign px_addr  = row_base + 19'(x);
  assign px_data  = color_r;

endmodule

// File: tb/tb_gpu_dc_rect_fill.sv
// Directed self-checking bench for gpu_dc_rect_fill with hand-computed addresses.
module tb_gpu_dc_rect_fill;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [9:0]  x0, y0, width, height;
  logic [11:0] color;
  logic        busy, done, px_valid, px_ready;
  logic [18:0] px_addr;
  logic [11:0] px_data;

  gpu_dc_rect_fill #(.H_RES(640), .V_RES(480)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .x0(x0), .y0(y0),
    .width(width), .height(height), .color(color), .busy(busy), .done(done),
    .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr), .px_data(px_data)
  );

  always #5 ACLK = ~ACLK;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [18:0] got_addr[$];
  logic [11:0] got_data[$];
  logic [18:0] exp_addr[$];
  int busy_cnt, done_cnt, done_cyc, last_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after start
  task automatic issue(input logic [9:0] xa, input logic [9:0] ya, input logic [9:0] w,
                       input logic [9:0] h, input logic [11:0] c);
    x0 = xa; y0 = ya; width = w; height = h; color = c; start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    x0 = 10'd7; y0 = 10'd9; width = 10'd100; height = 10'd100; color = 12'h0AA;
  endtask

  task automatic collect(input bit toggle, input bit mid_start);
    logic        prev_stall = 1'b0;
    logic [18:0] prev_addr = '0;
    logic [11:0] prev_data = '0;
    got_addr.delete(); got_data.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      start = (mid_start && cyc == 2);
      if (start) x0 = 10'd100;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_stall) begin
        check("stall_addr", 32'(px_addr), 32'(prev_addr));
        check("stall_data", 32'(px_data), 32'(prev_data));
      end
      px_ready = toggle ? ~px_ready : 1'b1;
      if (px_valid && px_ready) begin
        got_addr.push_back(px_addr);
        got_data.push_back(px_data);
        last_hs = cyc;
      end
      prev_stall = px_valid && !px_ready;
      prev_addr  = px_addr;
      prev_data  = px_data;
      if (done_cyc >= 0 && cyc > done_cyc) break;
      @(posedge ACLK); #1;
    end
    start = 1'b0;
    check("timeout_done_seen", 32'(done_cyc >= 0), 32'd1);
  endtask

  task automatic expect_run(input string tag, input logic [11:0] c, input int exp_busy);
    int n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    check({tag, "_count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(c));
    end
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_timing"}, 32'(done_cyc), 32'(last_hs + 1));
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    ARESET = 1'b1; start = 1'b0; px_ready = 1'b1;
    x0 = '0; y0 = '0; width = '0; height = '0; color = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(px_valid), 32'd0);
    check("rst_addr", 32'(px_addr), 32'd0);
    check("rst_data", 32'(px_data), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Basic 3x2 rectangle
    issue(10'd2, 10'd3, 10'd3, 10'd2, 12'hF00);
    check("basic_first_valid", 32'(px_valid), 32'd1);
    collect(1'b0, 1'b0);
    exp_addr = '{19'd1922, 19'd1923, 19'd1924, 19'd2562, 19'd2563, 19'd2564};
    expect_run("basic", 12'hF00, 6);
    check("basic_idle_after", 32'(busy | done | px_valid), 32'd0);

    // Clipping at the bottom-right corner
    issue(10'd638, 10'd479, 10'd5, 10'd5, 12'h0F0);
    collect(1'b0, 1'b0);
    exp_addr = '{19'd307198, 19'd307199};
    expect_run("clip", 12'h0F0, 2);

    // Degenerate commands
    issue(10'd2, 10'd3, 10'd0, 10'd2, 12'h123);
    collect(1'b0, 1'b0);
    exp_addr = {};
    expect_run("deg_w0", 12'h123, 0);
    issue(10'd640, 10'd3, 10'd3, 10'd2, 12'h123);
    collect(1'b0, 1'b0);
    expect_run("deg_x640", 12'h123, 0);
    issue(10'd2, 10'd480, 10'd3, 10'd2, 12'h123);
    collect(1'b0, 1'b0);
    expect_run("deg_y480", 12'h123, 0);

    // Backpressure with px_ready toggling
    px_ready = 1'b0;
    issue(10'd2, 10'd3, 10'd3, 10'd2, 12'hF00);
    collect(1'b1, 1'b0);
    exp_addr = '{19'd1922, 19'd1923, 19'd1924, 19'd2562, 19'd2563, 19'd2564};
    expect_run("bp", 12'hF00, -1);
    px_ready = 1'b1;

    // Second start mid-run is ignored
    issue(10'd2, 10'd3, 10'd3, 10'd2, 12'h00F);
    collect(1'b0, 1'b1);
    expect_run("restart", 12'h00F, 6);

    // Reset after three pixels accepted
    issue(10'd2, 10'd3, 10'd3, 10'd2, 12'hF00);
    repeat (3) begin @(posedge ACLK); #1; end
    check("rst_mid_addr_before", 32'(px_addr), 32'd2562);
    ARESET = 1'b1;
    #1;
    check("rst_mid_valid", 32'(px_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr", 32'(px_addr), 32'd0);
    check("rst_mid_data", 32'(px_data), 32'd0);
    @(posedge ACLK); #1;
    check("rst_mid_hold_done", 32'(done), 32'd0);
    ARESET = 1'b0;
    check("rst_release_valid", 32'(px_valid), 32'd0);
    issue(10'd2, 10'd3, 10'd3, 10'd2, 12'hF00);
    check("rst_restart_first", 32'(px_addr), 32'd1922);
    collect(1'b0, 1'b0);
    expect_run("after_rst", 12'hF00, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
